// File: rtl/multi_cycle_control.sv
// Multi-cycle datapath sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// illegal-encoding and memory-timeout trap, and a retired-instruction counter.
module multi_cycle_control #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             error,
    output logic [2:0]       state
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b100010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_ADDI  = 3'd1,
        C_LW    = 3'd2,
        C_SW    = 3'd3,
        C_BEQ   = 3'd4,
        C_BNE   = 3'd5,
        C_J     = 3'd6,
        C_ILL   = 3'd7
    } cls_t;

    state_t              state_q, state_d;
    cls_t                cls_q, dec_cls;
    logic [2:0]          rop_q, dec_aluop;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;
    logic                error_q;

    // Instruction class decode from the IR fields, captured in DECODE
    always_comb begin
        dec_cls   = C_ILL;
        dec_aluop = ALU_ADD;
        case (Op)
            OP_RTYPE: begin
                case (Funct)
                    FN_ADD: begin dec_cls = C_RTYPE; dec_aluop = ALU_ADD; end
                    FN_SUB: begin dec_cls = C_RTYPE; dec_aluop = ALU_SUB; end
                    FN_AND: begin dec_cls = C_RTYPE; dec_aluop = ALU_AND; end
                    FN_OR:  begin dec_cls = C_RTYPE; dec_aluop = ALU_OR;  end
                    default: ;
                endcase
            end
            OP_BEQ:  dec_cls = C_BEQ;
            OP_BNE:  dec_cls = C_BNE;
            OP_LW:   dec_cls = C_LW;
            OP_SW:   dec_cls = C_SW;
            OP_ADDI: dec_cls = C_ADDI;
            OP_J:    dec_cls = C_J;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            rop_q     <= ALU_ADD;
            wait_q    <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_q | (state_d == S_ERROR);
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                rop_q <= dec_aluop;
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next state and strobes; everything is held low while reset is high
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        PCWrite    = 1'b0;
        PCSrc      = 2'b00;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = ALU_ADD;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    state_d = (dec_cls == C_ILL) ? S_ERROR : S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_RTYPE: begin
                            RegDst  = 1'b1;
                            ALUOp   = rop_q;
                            state_d = S_WB;
                        end
                        C_ADDI: begin
                            ALUSrc  = 1'b1;
                            state_d = S_WB;
                        end
                        C_LW, C_SW: begin
                            ALUSrc  = 1'b1;
                            state_d = S_MEM;
                        end
                        C_BEQ, C_BNE: begin
                            ALUOp      = ALU_CMP;
                            PCSrc      = 2'b01;
                            PCWrite    = (cls_q == C_BEQ) ? Zero : ~Zero;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_J: begin
                            PCSrc      = 2'b10;
                            PCWrite    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_MEM: begin
                    ALUSrc   = 1'b1;
                    MemRead  = (cls_q == C_LW);
                    MemWrite = (cls_q == C_SW);
                    if (mem_ready) begin
                        if (cls_q == C_LW) begin
                            state_d = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                    if (cls_q == C_LW) begin
                        MemtoReg = 1'b1;
                    end else begin
                        RegDst = (cls_q == C_RTYPE);
                        ALUSrc = (cls_q == C_ADDI);
                        ALUOp  = (cls_q == C_RTYPE) ? rop_q : ALU_ADD;
                    end
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_ERROR;
            endcase
        end
    end

    assign retired = retired_q;
    assign error   = error_q;
    assign state   = state_q;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the processor datapath: it replaces the single-cycle combinational decoder with a state machine. Each instruction is split into FETCH / DECODE / EXEC / MEM / WB steps, so the ALU, adders and the single data memory port can be reused across cycles. It drives every datapath strobe (PC write, IR write, register-file and memory enables, mux selects, ALU op) and holds the memory step until a memory-ready handshake arrives. It also flags illegal encodings and memory timeouts, and counts retired instructions.

## Interface
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, max cycles MEM state waits for mem_ready before error (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Op  in  6  instruction[31:26] from IR
- Funct  in  6  instruction[5:0] from IR
- Zero  in  1  ALU equality flag (valid in EXEC)
- mem_ready  in  1  data memory completes access this cycle
- PCWrite  out  1  load PC this edge
- PCSrc  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- IRWrite  out  1  latch instruction register
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register-file write enable
- ALUSrc  out  1  1 = sign-extended immediate, 0 = RD2
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 111 compare
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  1  1 = memory data to register file
- instr_done  out  1  one-cycle pulse in final state of each instruction
- retired  out  CNT_W  retired-instruction count
- error  out  1  sticky illegal-opcode / timeout flag
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7

## Operation
- **Decoded set:**
  - R-type Op=000000 with Funct 100000 add, 100010 sub, 100100 and, 100101 or
  - beq 000100, bne 000101, lw 100011, sw 101011, addi 001000, j 100010
  - Any other Op, or an R-type with any other Funct, is illegal.
- **FETCH:**
  - IRWrite=1, PCWrite=1, PCSrc=00; next DECODE.
- **DECODE:**
  - All strobes 0.
  - Legal opcode → EXEC; illegal → ERROR.
- **EXEC, R-type:**
  - RegDst=1, ALUSrc=0, ALUOp per Funct (or = 011); next WB.
- **EXEC, addi:**
  - ALUSrc=1, ALUOp=000; next WB.
- **EXEC, lw/sw:**
  - ALUSrc=1, ALUOp=000; next MEM.
- **EXEC, beq/bne:**
  - ALUSrc=0, ALUOp=111, PCSrc=01.
  - PCWrite = Zero for beq, !Zero for bne.
  - instr_done=1; next FETCH.
- **EXEC, j:**
  - PCSrc=10, PCWrite=1, instr_done=1; next FETCH.
  - j performs no register write.
- **MEM:**
  - ALUSrc=1, ALUOp=000 held.
  - MemRead=1 (lw) or MemWrite=1 (sw), held while mem_ready=0.
  - On mem_ready=1: lw → WB; sw → instr_done=1 and next FETCH.
- **WB:**
  - RegWrite=1. RegDst/ALUSrc/ALUOp held from EXEC for R-type and addi.
  - MemtoReg=1 for lw, else 0; lw RegDst=0.
  - instr_done=1; next FETCH.
- **ERROR:**
  - All strobes 0, error=1; state held until reset.
- **Strobe defaults:** every strobe not listed for a state is 0.
- **retired counter:**
  - Increments on each cycle with instr_done=1.
  - Wraps from 2^CNT_W−1 to 0 without flagging.

## Timing
- **Reset:**
  - Sampled at the clk edge; when asserted, next state is FETCH.
  - After that edge: all strobes 0, PCSrc=00, ALUOp=000, retired=0, error=0, wait counter 0.
  - Outputs are Moore-decoded from state and the latched Op/Funct.
- **Reset mid-instruction:**
  - Aborts at the next edge. No PCWrite, RegWrite or MemWrite may assert in the cycle reset is high.
- **Latency in cycles with mem_ready already high:**
  - R/addi 4, lw 5, sw 4, beq/bne/j 3.
  - Each cycle mem_ready is low adds one cycle to lw/sw.
- **Memory wait counter:**
  - Counts cycles in MEM with mem_ready=0.
  - If it reaches MEM_TIMEOUT and mem_ready is still 0, next state is ERROR and MemRead/MemWrite deassert.
  - mem_ready=1 on the timeout cycle itself completes normally.
  - Counter clears on leaving MEM.
- **Zero:** sampled only in EXEC; ignored elsewhere.
- **mem_ready:** ignored outside MEM.
- **instr_done:** never asserts in FETCH, DECODE or ERROR.

## Test plan
- **Reset, then add:** reset for 2 cycles, then Op=000000/Funct=100000 → state 0,1,2,4,0. WB cycle: RegWrite=1, RegDst=1, ALUOp=000. retired=1.
- **beq/bne:** beq with Zero=1 → EXEC PCWrite=1, PCSrc=01. beq with Zero=0 → PCWrite=0. bne with Zero=0 → PCWrite=1. Each takes 3 cycles.
- **lw with wait:** lw with mem_ready low for 3 cycles → MemRead=1 for 4 MEM cycles, then WB with MemtoReg=1, RegDst=0. Total 8 cycles.
- **sw timeout:** sw with mem_ready stuck 0, MEM_TIMEOUT=15 → ERROR after 15 MEM-wait cycles, error=1. MemWrite low from the error cycle onward; error clears only on reset.
- **Illegal encodings:** Op=111111, or R-type Funct=000000 → DECODE→ERROR, no PCWrite/RegWrite afterwards. Reset asserted during a lw MEM cycle → FETCH next edge, retired=0.
- **Counter wrap:** with CNT_W=4, run 17 j instructions → retired goes 15 then 0 then 1.
